audio_adc_i2s_rx: RTL and testbench

- Receive side of the codec serial audio link: deserialises I2S-format ADC data from the codec (BCLK, ADCLRCK, ADCDAT) into parallel stereo sample pairs in the clk_clk domain.
- Complements the existing DAC transmit path and uses the same BCLK.
- Presents left/right words through a one-deep valid/ready output register to the downstream processing block.
- Codec pins are asynchronous to clk_clk and are synchronised internally.

---
 rtl/audio_adc_i2s_rx.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_audio_adc_i2s_rx.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_i2s_rx.sv
// -----------------------------------------------------------------------------
// audio_adc_i2s_rx
//
// Receive side of the codec serial audio link. Deserialises I2S ADC data
// (BCLK / ADCLRCK / ADCDAT, all asynchronous to clk_clk) into left/right sample
// pairs and presents them through a one-deep valid/ready output register.
//
// Ports:
//   clk_clk          system clock, at least 4x BCLK
//   reset_reset      asynchronous active-high reset
//   audio_i_BCLK     codec bit clock
//   audio_i_ADCLRCK  codec word select (0 = left, 1 = right)
//   audio_i_ADCDAT   codec serial ADC data
//   enable_i         capture enable
//   sample_left_o    left word of the held pair
//   sample_right_o   right word of the held pair
//   sample_valid_o   held pair is valid
//   sample_ready_i   consumer accepts the held pair
//   overflow_o       sticky: a completed pair was dropped
//   overflow_clr_i   clears overflow_o and frame_err_o
//   frame_err_o      sticky: a short word was received
// -----------------------------------------------------------------------------
module audio_adc_i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  audio_i_BCLK,
  input  logic                  audio_i_ADCLRCK,
  input  logic                  audio_i_ADCDAT,
  input  logic                  enable_i,
  output logic [DATA_WIDTH-1:0] sample_left_o,
  output logic [DATA_WIDTH-1:0] sample_right_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i,
  output logic                  frame_err_o
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_e;

  // Places bit b at position (DATA_WIDTH-1-n) so the word stays left-justified
  // however many bits eventually arrive; bits beyond DATA_WIDTH are ignored.
  function automatic logic [DATA_WIDTH-1:0] insert_bit(
    input logic [DATA_WIDTH-1:0] w,
    input logic [CNT_W-1:0]      n,
    input logic                  b
  );
    logic [DATA_WIDTH-1:0] one;
    one = {{(DATA_WIDTH-1){1'b0}}, b};
    if (n < CNT_FULL) begin
      return w | (one << (CNT_MSB - n));
    end
    return w;
  endfunction

  // Saturating bit counter increment.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] n);
    return (n == CNT_FULL) ? n : n + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   dat_s;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], audio_i_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], audio_i_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], audio_i_ADCDAT};
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detect and bit capture: one registered bit per BCLK rising edge
  // ---------------------------------------------------------------------------
  logic bclk_prev_q;
  logic bclk_rise;
  logic bit_vld_q;
  logic bit_lr_q;
  logic bit_d_q;
  logic lr_prev_q;

  assign bclk_rise = bclk_s & ~bclk_prev_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bclk_prev_q <= 1'b0;
      bit_vld_q   <= 1'b0;
      bit_lr_q    <= 1'b0;
      bit_d_q     <= 1'b0;
      lr_prev_q   <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      bit_vld_q   <= bclk_rise;
      if (bclk_rise) begin
        bit_lr_q <= lrck_s;
        bit_d_q  <= dat_s;
      end
      // lr_prev is tracked in every state so SYNC sees true transitions.
      if (bit_vld_q) begin
        lr_prev_q <= bit_lr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembly FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  held_q, held_d;

  logic                  word_close;
  logic [DATA_WIDTH-1:0] word_full;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  pair_done;
  logic                  short_close;

  // The bit just captured belongs to channel lr_prev; a change of lr means
  // it is the last bit of that word (I2S one-bit delay).
  assign word_close = bit_vld_q && (bit_lr_q != lr_prev_q);
  assign word_full  = insert_bit(shift_q, cnt_q, bit_d_q);
  assign cnt_inc    = cnt_sat_inc(cnt_q);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (word_close) state_d = bit_lr_q ? RIGHT : LEFT;
        LEFT:    if (word_close) state_d = RIGHT;
        RIGHT:   if (word_close) state_d = LEFT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    left_hold_d = left_hold_q;
    held_d      = held_q;
    pair_done   = 1'b0;
    short_close = 1'b0;
    if (!enable_i || state_q == IDLE) begin
      // Disabled: drop partial and held-left words.
      shift_d = '0;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else if (bit_vld_q) begin
      unique case (state_q)
        SYNC: begin
          // Bits before the first transition are discarded.
          shift_d = '0;
          cnt_d   = '0;
        end
        LEFT, RIGHT: begin
          if (word_close) begin
            shift_d     = '0;
            cnt_d       = '0;
            short_close = (cnt_inc != CNT_FULL);
            if (state_q == LEFT) begin
              left_hold_d = word_full;
              held_d      = 1'b1;
            end else if (held_q) begin
              pair_done = 1'b1;
              held_d    = 1'b0;
            end
          end else begin
            shift_d = word_full;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          shift_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      left_hold_q <= '0;
      held_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      left_hold_q <= left_hold_d;
      held_q      <= held_d;
    end
  end

  // ---------------------------------------------------------------------------
  // One-deep output register with valid/ready and sticky flags
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
  logic [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  ferr_q, ferr_d;

  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = valid_q;
    // Clear first so a same-cycle set takes priority.
    ovf_d       = overflow_clr_i ? 1'b0 : ovf_q;
    ferr_d      = overflow_clr_i ? 1'b0 : ferr_q;
    if (short_close) begin
      ferr_d = 1'b1;
    end
    if (pair_done) begin
      if (!valid_q || sample_ready_i) begin
        out_left_d  = left_hold_q;
        out_right_d = word_full;
        valid_d     = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  assign sample_left_o  = out_left_q;
  assign sample_right_o = out_right_q;
  assign sample_valid_o = valid_q;
  assign overflow_o     = ovf_q;
  assign frame_err_o    = ferr_q;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_audio_adc_i2s_rx
//
// Drives I2S word streams into audio_adc_i2s_rx at BCLK = clk/16 and checks
// the emitted pairs and flags against a word-level reference model.
// -----------------------------------------------------------------------------
module tb_audio_adc_i2s_rx;

  localparam int DW = 24;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic bclk  = 1'b0;
  logic lrck  = 1'b0;
  logic dat   = 1'b0;
  logic en    = 1'b0;
  logic ready = 1'b1;
  logic clr   = 1'b0;

  logic [DW-1:0] left_o;
  logic [DW-1:0] right_o;
  logic          valid_o;
  logic          ovf_o;
  logic          ferr_o;

  audio_adc_i2s_rx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .audio_i_BCLK   (bclk),
    .audio_i_ADCLRCK(lrck),
    .audio_i_ADCDAT (dat),
    .enable_i       (en),
    .sample_left_o  (left_o),
    .sample_right_o (right_o),
    .sample_valid_o (valid_o),
    .sample_ready_i (ready),
    .overflow_o     (ovf_o),
    .overflow_clr_i (clr),
    .frame_err_o    (ferr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  // Reference model state (word level)
  pair_t         exp_q[$];
  logic [DW-1:0] m_held;
  bit            m_held_v   = 0;
  bit            m_synced   = 0;
  bit            m_en       = 0;
  bit            m_ovf      = 0;
  bit            m_err      = 0;
  bit            m_blocking = 0;

  // Stream state: the LSB of each word goes out with the next word's lr
  bit          pend_v = 0;
  logic        pend_bit;
  bit          pend_ch;
  logic [31:0] pend_val;
  int          pend_len;

  // One-shot actions tied to the next closing slot
  bit pulse_ready = 0;
  bit pulse_clr   = 0;
  bit meas        = 0;
  int rst_bit     = -1;
  int en_bit      = -1;

  int            xfers = 0;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] justify(input logic [31:0] v, input int n);
    logic [63:0] w;
    w = {32'd0, v} & ((64'd1 << n) - 64'd1);
    if (n >= DW) w = w >> (n - DW);
    else         w = w << (DW - n);
    return w[DW-1:0];
  endfunction

  // A word of channel ch, n bits of v, has just ended.
  task automatic model_close(input bit ch, input logic [31:0] v, input int n);
    pair_t p;
    if (!m_en) return;
    if (!m_synced) begin
      m_synced = 1;
      return;
    end
    if (n < DW) m_err = 1;
    if (ch == 1'b0) begin
      m_held   = justify(v, n);
      m_held_v = 1;
    end else if (m_held_v) begin
      m_held_v = 0;
      if (m_blocking && exp_q.size() != 0 && !pulse_ready) begin
        m_ovf = 1;
      end else begin
        p.l = m_held;
        p.r = justify(v, n);
        exp_q.push_back(p);
      end
    end
  endtask

  // Consumer side: every transfer must match the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && valid_o && ready) begin
      check("pair_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("xfer_left", 64'(left_o), 64'(exp_q[0].l));
        check("xfer_right", 64'(right_o), 64'(exp_q[0].r));
        void'(exp_q.pop_front());
      end
      last_l = left_o;
      last_r = right_o;
      xfers++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_slot(input logic lr, input logic d);
    bit seen;
    int lat;
    step();
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (7) step();
    bclk = 1'b1;
    seen = 0;
    lat  = 99;
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 3 && pulse_ready) ready = 1'b1;
      if (n == 4 && pulse_ready) ready = 1'b0;
      if (n == 3 && pulse_clr)   clr   = 1'b1;
      if (n == 4 && pulse_clr)   clr   = 1'b0;
      if (meas && !seen && valid_o) begin
        seen = 1;
        lat  = n;
      end
    end
    if (meas) check("latency", 64'(lat), 64'(SS + 2));
    meas        = 0;
    pulse_ready = 0;
    pulse_clr   = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_left", 64'(left_o), 64'd0);
    check("rst_right", 64'(right_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    exp_q.delete();
    m_synced = 0;
    m_held_v = 0;
    m_ovf    = 0;
    m_err    = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_word(input bit ch, input logic [31:0] v, input int n);
    if (pend_v) begin
      if (pulse_clr) begin
        m_ovf = 0;
        m_err = 0;
      end
      model_close(pend_ch, pend_val, pend_len);
      send_slot(ch, pend_bit);
    end
    for (int i = n - 1; i >= 1; i--) begin
      send_slot(ch, v[i]);
      if (i == rst_bit) begin
        rst_bit = -1;
        do_reset();
      end
      if (i == en_bit) begin
        en_bit = -1;
        en     = 1'b1;
        m_en   = 1;
      end
    end
    pend_v   = 1;
    pend_bit = v[0];
    pend_ch  = ch;
    pend_val = v;
    pend_len = n;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_word(1'b0, l, n);
    send_word(1'b1, r, n);
  endtask

  task automatic pulse_clear();
    step();
    clr = 1'b1;
    step();
    clr   = 1'b0;
    m_ovf = 0;
    m_err = 0;
  endtask

  int x0;

  initial begin
    // Reset state
    repeat (3) step();
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_left", 64'(left_o), 64'd0);
    check("reset_right", 64'(right_o), 64'd0);
    check("reset_ovf", 64'(ovf_o), 64'd0);
    check("reset_ferr", 64'(ferr_o), 64'd0);
    rst = 1'b0;
    step();

    // Normal 24-bit frames; the first frame is consumed by SYNC
    en   = 1'b1;
    m_en = 1;
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    meas = 1;
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    check("normal_pairs", 64'(xfers), 64'd2);
    check("normal_left", 64'(last_l), 64'hA5A5A5);
    check("normal_right", 64'(last_r), 64'h3C3C3C);
    check("normal_ferr", 64'(ferr_o), 64'd0);
    check("normal_ovf", 64'(ovf_o), 64'd0);

    // Short words, then long words
    send_frame(32'h1234, 32'hBEEF, 16);
    send_frame(32'h1234, 32'hBEEF, 16);
    check("short_ferr", 64'(ferr_o), 64'd1);
    check("short_left", 64'(last_l), 64'h123400);
    check("short_right", 64'(last_r), 64'hBEEF00);
    send_word(1'b0, 32'h89ABCDEF, 32);
    check("ferr_sticky", 64'(ferr_o), 64'd1);
    pulse_clear();
    check("ferr_cleared", 64'(ferr_o), 64'd0);
    send_word(1'b1, 32'h76543210, 32);
    send_word(1'b0, 32'hA5A5A5, 24);
    check("long_left", 64'(last_l), 64'h89ABCD);
    check("long_right", 64'(last_r), 64'h765432);
    check("long_ferr", 64'(ferr_o), 64'd0);
    send_word(1'b1, 32'h3C3C3C, 24);

    // Randomized words of 16..32 bits
    for (int k = 0; k < 6; k++) begin
      send_word(1'b0, $urandom, int'($urandom_range(16, 32)));
      send_word(1'b1, $urandom, int'($urandom_range(16, 32)));
    end
    check("rand_ferr", 64'(ferr_o), 64'(m_err));
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    pulse_clear();

    // Backpressure
    send_word(1'b0, 32'h111111, 24);
    ready      = 1'b0;
    m_blocking = 1;
    send_word(1'b1, 32'h222222, 24);
    send_frame(32'h333333, 32'h444444, 24);
    send_frame(32'h555555, 32'h666666, 24);
    check("bp_ovf", 64'(ovf_o), 64'd1);
    check("bp_valid", 64'(valid_o), 64'd1);
    check("bp_hold_left", 64'(left_o), 64'h111111);
    check("bp_hold_right", 64'(right_o), 64'h222222);
    pulse_clr = 1;
    send_word(1'b0, 32'h777777, 24);
    check("ovf_set_wins", 64'(ovf_o), 64'd1);
    check("bp_still_left", 64'(left_o), 64'h111111);
    pulse_clear();
    check("ovf_cleared", 64'(ovf_o), 64'd0);
    send_word(1'b1, 32'h888888, 24);
    pulse_ready = 1;
    send_word(1'b0, 32'h999999, 24);
    check("simul_valid", 64'(valid_o), 64'd1);
    check("simul_left", 64'(left_o), 64'h777777);
    check("simul_right", 64'(right_o), 64'h888888);
    check("simul_ovf", 64'(ovf_o), 64'd0);
    ready      = 1'b1;
    m_blocking = 0;
    repeat (3) step();
    send_word(1'b1, 32'hAAAAAA, 24);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-left-word with a pair held
    send_word(1'b0, 32'h0F0F0F, 24);
    ready      = 1'b0;
    m_blocking = 1;
    send_word(1'b1, 32'hF0F0F0, 24);
    rst_bit = 10;
    send_word(1'b0, 32'h123456, 24);
    ready      = 1'b1;
    m_blocking = 0;
    x0 = xfers;
    send_word(1'b1, 32'h654321, 24);
    send_frame(32'hC0FFEE, 32'hFACADE, 24);
    send_word(1'b0, 32'h0A0B0C, 24);
    check("post_rst_pairs", 64'(xfers - x0), 64'd1);
    check("post_rst_left", 64'(last_l), 64'hC0FFEE);
    check("post_rst_right", 64'(last_r), 64'hFACADE);

    // Disable with a held left word, re-enable mid-right-word
    send_word(1'b1, 32'h0D0E0F, 24);
    x0       = xfers;
    en       = 1'b0;
    m_en     = 0;
    m_held_v = 0;
    m_synced = 0;
    send_word(1'b0, 32'h101010, 24);
    en_bit = 12;
    send_word(1'b1, 32'h202020, 24);
    send_frame(32'h303030, 32'h404040, 24);
    send_word(1'b0, 32'h505050, 24);
    check("en_pairs", 64'(xfers - x0), 64'd1);
    check("en_left", 64'(last_l), 64'h303030);
    check("en_right", 64'(last_r), 64'h404040);

    // Close the last right word and settle
    send_word(1'b1, 32'h606060, 24);
    send_word(1'b0, 32'h707070, 24);
    repeat (4) step();
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_ovf", 64'(ovf_o), 64'(m_ovf));
    check("final_ferr", 64'(ferr_o), 64'(m_err));
    check("final_left", 64'(last_l), 64'h505050);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
